// File: rtl/norm_scaler_mc_pkg.sv
// norm_pkg: shared definitions for the norm_scaler_mc frame normaliser.
//   - norm_state_t    : frame sequencer states.
//   - beats_per_frame : AXI beats in one frame for a given lane count.
//   - *_DEF           : default pixel, output and coefficient-fraction widths.
package norm_pkg;

    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned OUT_W_DEF  = 8;
    localparam int unsigned FRAC_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } norm_state_t;

    function automatic int unsigned beats_per_frame(input int unsigned rows,
                                                    input int unsigned cols,
                                                    input int unsigned lanes);
        return (rows * cols) / lanes;
    endfunction

endpackage

// File: rtl/norm_scaler_mc_recip_divider.sv
// recip_divider: sequential restoring divider producing the scale coefficient
//   quotient = floor(((2^OUT_W-1) << FRAC_W) / divisor), one bit per cycle,
//   exactly OUT_W+FRAC_W cycles after start. A zero divisor yields 0 in the
//   same number of cycles.
// Ports:
//   clk, reset     : clock, synchronous active-high reset.
//   start          : begin a division (divisor captured on this cycle).
//   divisor        : DEN_W-bit divisor.
//   busy           : division in progress.
//   done           : high in the cycle the final quotient bit is computed;
//                    quotient is valid from the following cycle on.
//   quotient       : OUT_W+FRAC_W-bit result, held until the next start.
module recip_divider
    import norm_pkg::*;
#(
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned DEN_W  = PIX_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DEN_W-1:0]        divisor,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W+FRAC_W-1:0] quotient
);

    localparam int unsigned CW    = OUT_W + FRAC_W;
    localparam int unsigned CNT_W = $clog2(CW);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CW - 1);
    localparam logic [CW-1:0]    DIVIDEND  = {{OUT_W{1'b1}}, {FRAC_W{1'b0}}};

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    num_q, num_d;
    logic [CW-1:0]    quo_q, quo_d;

    logic [DEN_W:0]   rem_sh;
    logic [DEN_W-1:0] rem_sub;
    logic             take;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        num_d  = num_q;
        quo_d  = quo_q;
        rem_sh = {rem_q, num_q[CW-1]};
        // Difference is below the divisor whenever it is taken, so DEN_W bits suffice.
        rem_sub = rem_sh[DEN_W-1:0] - dvs_q;
        take    = (dvs_q != '0) && (rem_sh >= {1'b0, dvs_q});
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            dvs_d  = divisor;
            num_d  = DIVIDEND;
            quo_d  = '0;
        end else if (busy_q) begin
            rem_d = take ? rem_sub : rem_sh[DEN_W-1:0];
            num_d = {num_q[CW-2:0], 1'b0};
            quo_d = {quo_q[CW-2:0], take};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            num_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            num_q  <= num_d;
            quo_q  <= quo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == LAST_STEP);
    assign quotient = quo_q;

endmodule

// File: rtl/norm_scaler_mc.sv
// norm_scaler_mc: per-frame normaliser for the post-crop pixel stream.
//   On ap_start the denominator is latched and a fixed-point coefficient is
//   computed; every lane is then scaled as pix*(2^OUT_W-1)/den, saturated,
//   through a two-stage AXI-Stream pipeline with full backpressure.
// Build option: define NORM_SCALER_ROUND_EN to round half up in stage 2
//   instead of truncating; latency and handshakes are unchanged.
// Ports:
//   clk, reset         : clock, synchronous active-high reset.
//   ap_start/ap_ready  : frame start (sampled in IDLE) / idle indication.
//   ap_done            : one-cycle pulse after the last output beat.
//   den, den_err       : denominator (latched at start) / sticky den==0 flag.
//   s_axis_*           : input beats, LANES*PIX_W, lane 0 in LSBs.
//   m_axis_*           : output beats, LANES*OUT_W, tlast on the final beat.
module norm_scaler_mc
    import norm_pkg::*;
#(
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned FRAC_W   = FRAC_W_DEF,
    parameter int unsigned LANES    = 1,
    parameter int unsigned OUT_ROWS = 10,
    parameter int unsigned OUT_COLS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    output logic                   ap_ready,
    output logic                   ap_done,
    input  logic [PIX_W-1:0]       den,
    output logic                   den_err,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [LANES*PIX_W-1:0] s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [LANES*OUT_W-1:0] m_axis_tdata,
    output logic                   m_axis_tlast
);

    localparam int unsigned BEATS = beats_per_frame(OUT_ROWS, OUT_COLS, LANES);
    localparam int unsigned CW    = OUT_W + FRAC_W;
    localparam int unsigned PW    = PIX_W + CW;
    // Shifted result keeps one extra bit for the rounding carry.
    localparam int unsigned SW    = PW - FRAC_W + 1;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [SW-1:0]    SAT_MAX   = {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef NORM_SCALER_ROUND_EN
    localparam logic [PW:0] ROUND_BIAS = {{(PW-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`else
    localparam logic [PW:0] ROUND_BIAS = '0;
`endif

    if ((OUT_ROWS * OUT_COLS) % LANES != 0) begin : g_lanes_check
        $error("norm_scaler_mc: OUT_ROWS*OUT_COLS must be divisible by LANES");
    end

    norm_state_t state_q, state_d;
    logic ap_ready_q, ap_ready_d;
    logic ap_done_q, ap_done_d;
    logic den_err_q, den_err_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic [LANES-1:0][PW-1:0] s1_prod_q, s1_prod_d, lane_prod;
    logic [LANES*OUT_W-1:0]   s2_data_q, s2_data_d, lane_out;

    logic          pipe_en, in_fire, out_fire;
    logic          div_start, div_busy, div_done;
    logic [CW-1:0] coef;

    recip_divider #(
        .OUT_W  (OUT_W),
        .FRAC_W (FRAC_W),
        .DEN_W  (PIX_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .divisor  (den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (coef)
    );

    assign pipe_en       = !s2_valid_q || m_axis_tready;
    assign s_axis_tready = (state_q == ST_STREAM) && (in_cnt_q < BEATS_C) && pipe_en;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = s2_valid_q && m_axis_tready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SW-1:0] shifted;
        assign lane_prod[l] = PW'(s_axis_tdata[l*PIX_W +: PIX_W]) * PW'(coef);
        assign shifted      = SW'(({1'b0, s1_prod_q[l]} + ROUND_BIAS) >> FRAC_W);
        assign lane_out[l*OUT_W +: OUT_W] = (shifted > SAT_MAX) ? {OUT_W{1'b1}}
                                                                : shifted[OUT_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        ap_ready_d = ap_ready_q;
        ap_done_d  = 1'b0;
        den_err_d  = den_err_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        div_start  = 1'b0;

        if (in_fire) begin
            in_cnt_d = in_cnt_q + 1'b1;
        end
        if (out_fire) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        // Whole pipeline advances together; it only stalls when stage 2 is blocked.
        if (pipe_en) begin
            s1_valid_d = in_fire;
            s2_valid_d = s1_valid_q;
            if (in_fire) begin
                s1_prod_d = lane_prod;
            end
            if (s1_valid_q) begin
                s2_data_d = lane_out;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ap_start && !div_busy) begin
                    state_d    = ST_CALC;
                    ap_ready_d = 1'b0;
                    den_err_d  = (den == '0);
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    div_start  = 1'b1;
                end
            end
            ST_CALC: begin
                if (div_done) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_fire && (out_cnt_q == LAST_BEAT)) begin
                    state_d   = ST_DONE;
                    ap_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                ap_ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ap_ready_q <= 1'b1;
            ap_done_q  <= 1'b0;
            den_err_q  <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ap_ready_q <= ap_ready_d;
            ap_done_q  <= ap_done_d;
            den_err_q  <= den_err_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign ap_ready      = ap_ready_q;
    assign ap_done       = ap_done_q;
    assign den_err       = den_err_q;
    assign m_axis_tvalid = s2_valid_q;
    assign m_axis_tdata  = s2_data_q;
    assign m_axis_tlast  = s2_valid_q && (out_cnt_q == LAST_BEAT);

endmodule

// File: doc/norm_scaler_mc.md
Name: norm_scaler_mc

Overview:
- Successor frame normaliser for the post-crop pixel stream.
- Per frame, latches a denominator at ap_start and computes a fixed-point scale coefficient with an internal sequential divider. Each lane of each beat is then scaled to the full output range: out = pix*(2^OUT_W-1)/den, saturated.
- Multi-lane, width-parametrised, two-stage pipeline with full AXI-Stream backpressure. Generates tlast and drives ap control for the downstream sequencer.

Parameters:
- PIX_W, 8, input pixel width per lane.
- OUT_W, 8, output pixel width per lane.
- FRAC_W, 24, fractional bits of the coefficient.
- LANES, 1, pixels per AXI beat; OUT_ROWS*OUT_COLS must be divisible by LANES (elaboration-time assertion).
- OUT_ROWS, 10, frame rows.
- OUT_COLS, 10, frame columns.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  start one frame; sampled only in IDLE.
- ap_ready  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse after the last output beat handshakes.
- den  in  PIX_W  normalisation denominator; latched on accepted ap_start.
- den_err  out  1  sticky: latched den was 0; cleared on next accepted ap_start.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  LANES*PIX_W  input lanes, lane 0 in LSBs.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output beat ready.
- m_axis_tdata  out  LANES*OUT_W  scaled lanes, lane 0 in LSBs.
- m_axis_tlast  out  1  marks the final beat of the frame.

Behaviour:
- Reset clears all state:
  - state=IDLE; counters 0; pipeline valids 0.
  - Outputs: ap_ready=1; ap_done=0; den_err=0; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tlast=0.
  - Reset mid-frame abandons the frame; no ap_done is issued.
- Constants: BEATS = OUT_ROWS*OUT_COLS/LANES; DIV_N = OUT_W+FRAC_W; coefficient width CW = DIV_N.
- FSM: IDLE -> CALC -> STREAM -> DONE -> IDLE.
  - IDLE:
    - ap_start=1 latches den, clears den_err and counters, goes to CALC.
    - If den==0, sets den_err.
  - CALC:
    - Restoring divider, one quotient bit per cycle, exactly DIV_N cycles.
    - coef = floor(((2^OUT_W-1) << FRAC_W) / den).
    - den==0 skips division and sets coef=0, but still spends DIV_N cycles so timing is deterministic.
    - Then goes to STREAM.
  - STREAM:
    - s_axis_tready = (in_cnt < BEATS) && pipe_en, where pipe_en = !stage2_valid || m_axis_tready.
    - Beat accepted when tvalid&&tready; increments in_cnt.
    - Leaves when out_cnt reaches BEATS, i.e. after the last output handshake.
  - DONE: ap_done=1 for exactly one cycle; next state IDLE.
- ap_start outside IDLE is ignored; it does not restart or alter the current frame.
- Pipeline (global stall when !pipe_en):
  - Stage 1 registers per-lane product pix*coef (PIX_W+CW bits).
  - Stage 2 registers shifted result: out = product >> FRAC_W, saturated to 2^OUT_W-1.
  - Latency: beat accepted at cycle t appears on m_axis at t+2 if m_axis_tready stays high.
  - Throughput: 1 beat/cycle sustained.
- m_axis_tlast = 1 on the beat whose out_cnt == BEATS-1.
- m_axis_tvalid/tdata/tlast hold stable while tvalid && !tready (AXI rule).
- Input beats beyond BEATS are not accepted (tready=0) until the next frame.
- den_err frames stream normally with all-zero data, so the pipeline never hangs.

Optional Feature:
- Macro NORM_SCALER_ROUND_EN.
- Defined: stage 2 adds 2^(FRAC_W-1) before the shift (round half up), then saturates.
- Undefined: truncation only.
- Latency and handshakes are identical in both builds.

Decomposition:
- Package norm_pkg:
  - state enum type norm_state_t.
  - helper function beats_per_frame(rows, cols, lanes).
  - localparam defaults for PIX_W, OUT_W, FRAC_W.
- Sub-module recip_divider:
  - Sequential restoring divider.
  - Interface: start, divisor, busy, done pulse, quotient[CW-1:0].
  - Parametrised by OUT_W and FRAC_W.
- Lane multiply/saturate stays a generate loop in the top module.

Test Plan:
- Defaults, den=255, ramp pix 0..99 -> outputs equal inputs; tlast only on beat 99; ap_done pulses once, DIV_N+2+100+1 cycles after ap_start with tready tied high.
- den=51, pix 40 and 60 -> 200 and 255 (300 saturated).
- den=2, pix 1 -> 127 truncating; 128 with NORM_SCALER_ROUND_EN.
- LANES=4, den=255, m_axis_tready low for 5 cycles mid-frame -> no beat lost or duplicated; tdata stable while stalled; 25 beats total.
- den=0 -> den_err=1; 100 zero pixels out; ap_done pulses; next ap_start with den=255 clears den_err.
- Reset asserted mid-STREAM -> next cycle ap_ready=1, m_axis_tvalid=0, no ap_done; a fresh frame then completes correctly.
